// File: rtl/noc_inject_arbiter_if.sv
// Injection-side bundle of noc_inject_arbiter: requester handshake, router flit,
// credit returns and the debug/scoreboard observation signals.
interface noc_inject_arbiter_if #(
    parameter int WIDTH     = 128,
    parameter int NUM_VC    = 2,
    parameter int NUM_REQ   = 4,
    parameter int BUF_DEPTH = 8
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a requester flit moves on a cycle where req_valid[i] & req_ready[i];
    // req_valid must stay high with a stable flit until that happens, and req_ready
    // may depend combinationally on req_valid and the flit contents.
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_flit;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         o_flit_out;
    logic [NUM_VC-1:0]        credits_in;
    logic [NUM_VC*CW-1:0]     credit_cnt;
    logic [OW-1:0]            owner;
    logic                     proto_err;

    modport master (
        input  req_valid, req_flit, credits_in,
        output req_ready, o_flit_out, credit_cnt, owner, proto_err
    );

    modport slave (
        output req_valid, req_flit, credits_in,
        input  req_ready, o_flit_out, credit_cnt, owner, proto_err
    );
endinterface

// File: rtl/noc_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one NoC router injection port among
// NUM_REQ requesters, with per-VC credit tracking against the downstream buffer.
module noc_inject_arbiter #(
    parameter int WIDTH     = 128,
    parameter int N         = 16,
    parameter int NUM_VC    = 2,
    parameter int NUM_REQ   = 4,
    parameter int BUF_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    noc_inject_arbiter_if.master bus,
    output logic                 o_state
);
    localparam int VCW      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CW       = $clog2(BUF_DEPTH + 1);
    localparam int OW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int P_HEAD   = WIDTH - 2;
    localparam int P_TAIL   = WIDTH - 3;
    localparam int VC_LSB   = WIDTH - 3 - VCW;
    localparam int DEST_LSB = VC_LSB - $clog2(N);
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [OW-1:0]    r_rr, r_owner;
    logic [VCW-1:0]   r_lock_vc;
    logic [CW-1:0]    r_cnt [NUM_VC];
    logic [WIDTH-1:0] r_flit;
    logic             r_err;

    logic [WIDTH-1:0]   w_flit [NUM_REQ];
    logic [NUM_REQ-1:0] w_elig, w_ready, w_unused_valid_bits;
    logic               w_found, w_send, w_err_set, w_ovf;
    logic [OW-1:0]      w_win, w_rr_nxt;
    logic [WIDTH-1:0]   w_send_flit;
    logic [VCW-1:0]     w_send_vc;
    logic [CW-1:0]      w_cnt_nxt [NUM_VC];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_flit[i]              = bus.req_flit[i*WIDTH +: WIDTH];
            w_unused_valid_bits[i] = w_flit[i][WIDTH-1];
            w_elig[i] = bus.req_valid[i] & w_flit[i][P_HEAD] &
                        (r_cnt[w_flit[i][VC_LSB +: VCW]] != '0);
        end
    end

    // First eligible head searching upward from the round-robin pointer, with wrap.
    always_comb begin
        logic [OW:0] w_sum;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr} + (OW+1)'(k);
            if (w_sum >= (OW+1)'(NUM_REQ)) w_sum = w_sum - (OW+1)'(NUM_REQ);
            if (!w_found && w_elig[w_sum[OW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[OW-1:0];
            end
        end
        w_rr_nxt = (w_win == OW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_send      = 1'b0;
        w_send_flit = {1'b1, w_flit[r_owner][WIDTH-2:0]};
        w_send_vc   = r_lock_vc;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_ready[w_win] = 1'b1;
                    w_send         = 1'b1;
                    w_send_flit    = {1'b1, w_flit[w_win][WIDTH-2:0]};
                    w_send_vc      = w_flit[w_win][VC_LSB +: VCW];
                    if (!w_flit[w_win][P_TAIL]) w_state_nxt = S_LOCKED;
                end else begin
                    // Stray body flits are drained so the requester cannot wedge the port.
                    for (int i = 0; i < NUM_REQ; i++)
                        if (bus.req_valid[i] && !w_flit[i][P_HEAD]) w_ready[i] = 1'b1;
                    w_err_set = |w_ready;
                end
            end
            S_LOCKED: begin
                if (r_cnt[r_lock_vc] != '0) w_ready[r_owner] = 1'b1;
                if (bus.req_valid[r_owner] && w_ready[r_owner]) begin
                    w_send      = 1'b1;
                    w_err_set   = w_flit[r_owner][P_HEAD];
                    w_send_flit = {1'b1, 1'b0, w_flit[r_owner][P_TAIL], r_lock_vc,
                                   w_flit[r_owner][VC_LSB-1:DEST_LSB],
                                   w_flit[r_owner][DEST_LSB-1:0]};
                    if (w_flit[r_owner][P_TAIL]) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A return and a send on the same VC cancel; a return into a full counter is dropped.
    always_comb begin
        logic w_dec;
        w_ovf = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_cnt_nxt[v] = r_cnt[v];
            w_dec        = w_send && (w_send_vc == VCW'(v));
            if (bus.credits_in[v] && !w_dec) begin
                if (r_cnt[v] == FULL) w_ovf = 1'b1;
                else                  w_cnt_nxt[v] = r_cnt[v] + 1'b1;
            end else if (!bus.credits_in[v] && w_dec) begin
                w_cnt_nxt[v] = r_cnt[v] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_rr      <= '0;
            r_owner   <= '0;
            r_lock_vc <= '0;
            r_flit    <= '0;
            r_err     <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) r_cnt[v] <= FULL;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= r_err | w_err_set | w_ovf;
            for (int v = 0; v < NUM_VC; v++) r_cnt[v] <= w_cnt_nxt[v];
            if (w_send) r_flit <= w_send_flit;
            else        r_flit[WIDTH-1] <= 1'b0;
            if (r_state == S_IDLE && w_send) begin
                r_owner   <= w_win;
                r_lock_vc <= w_send_vc;
                r_rr      <= w_rr_nxt;
            end
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_cnt
        assign bus.credit_cnt[v*CW +: CW] = r_cnt[v];
    end

    assign bus.req_ready  = reset ? w_ready : '0;
    assign bus.o_flit_out = r_flit;
    assign bus.owner      = r_owner;
    assign bus.proto_err  = r_err;
    assign o_state        = r_state;
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Bench for noc_inject_arbiter: directed scenarios plus random packet traffic, all
// outputs compared every cycle against a transaction-level model of the arbiter.
module tb_noc_inject_arbiter;
    localparam int WIDTH = 128, N = 16, NUM_VC = 2, NUM_REQ = 4, BUF_DEPTH = 8;
    localparam int CW = 4, DW = 4;
    localparam int P_VALID = WIDTH - 1, P_HEAD = WIDTH - 2, P_TAIL = WIDTH - 3;
    localparam int P_VC = WIDTH - 4, P_DEST = WIDTH - 4 - DW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic st;

    noc_inject_arbiter_if #(.WIDTH(WIDTH), .NUM_VC(NUM_VC), .NUM_REQ(NUM_REQ),
                            .BUF_DEPTH(BUF_DEPTH)) bus ();

    noc_inject_arbiter #(.WIDTH(WIDTH), .N(N), .NUM_VC(NUM_VC), .NUM_REQ(NUM_REQ),
                         .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus), .o_state(st)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Model: packet lock, round-robin start point, credit pool and error flag.
    bit                 m_locked, m_err;
    int                 m_owner, m_lock_vc, m_rr, m_win;
    int                 m_cred [NUM_VC];
    logic [WIDTH-1:0]   m_out;
    logic [NUM_REQ-1:0] m_rdy, m_acc;
    logic [NUM_VC-1:0]  m_cin;
    logic [WIDTH-1:0]   exp_q[$];

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] mk_flit(input bit h, input bit t, input bit vc,
                                                 input logic [3:0] dest, input logic [31:0] data);
        logic [WIDTH-1:0] f;
        f = '0;
        f[P_HEAD] = h;
        f[P_TAIL] = t;
        f[P_VC] = vc;
        f[P_DEST +: DW] = dest;
        f[31:0] = data;
        return f;
    endfunction

    function automatic logic [WIDTH-1:0] sent(input logic [WIDTH-1:0] f);
        logic [WIDTH-1:0] g;
        g = f;
        g[P_VALID] = 1'b1;
        return g;
    endfunction

    function automatic logic [WIDTH-1:0] fl(input int i);
        return bus.req_flit[i*WIDTH +: WIDTH];
    endfunction

    function automatic logic [NUM_VC*CW-1:0] exp_cnt();
        logic [NUM_VC*CW-1:0] e;
        for (int v = 0; v < NUM_VC; v++) e[v*CW +: CW] = m_cred[v][CW-1:0];
        return e;
    endfunction

    task automatic set_flit(input int i, input logic [WIDTH-1:0] f);
        bus.req_flit[i*WIDTH +: WIDTH] = f;
    endtask

    task automatic model_reset();
        m_locked = 0; m_err = 0; m_owner = 0; m_lock_vc = 0; m_rr = 0;
        for (int v = 0; v < NUM_VC; v++) m_cred[v] = BUF_DEPTH;
        m_out = '0;
        exp_q.delete();
    endtask

    task automatic model_eval();
        logic [WIDTH-1:0] f;
        m_rdy = '0;
        m_win = -1;
        if (!m_locked) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (m_rr + k) % NUM_REQ;
                f = fl(i);
                if (m_win < 0 && bus.req_valid[i] && f[P_HEAD] && m_cred[int'(f[P_VC])] > 0) m_win = i;
            end
            if (m_win >= 0) m_rdy[m_win] = 1'b1;
            else for (int i = 0; i < NUM_REQ; i++) begin
                f = fl(i);
                if (bus.req_valid[i] && !f[P_HEAD]) m_rdy[i] = 1'b1;
            end
        end else if (m_cred[m_lock_vc] > 0) begin
            m_rdy[m_owner] = 1'b1;
        end
    endtask

    task automatic model_step();
        logic [WIDTH-1:0] f;
        bit snd;
        int svc;
        snd = 0; svc = -1; f = '0;
        if (!m_locked) begin
            if (m_win >= 0 && m_acc[m_win]) begin
                f = sent(fl(m_win));
                svc = int'(f[P_VC]);
                m_owner = m_win; m_lock_vc = svc; m_rr = (m_win + 1) % NUM_REQ;
                m_locked = !f[P_TAIL];
                snd = 1;
            end else if (m_acc != '0) begin
                m_err = 1;
            end
        end else if (m_acc[m_owner]) begin
            f = sent(fl(m_owner));
            if (f[P_HEAD]) begin m_err = 1; f[P_HEAD] = 1'b0; end
            f[P_VC] = m_lock_vc[0];
            svc = m_lock_vc;
            if (f[P_TAIL]) m_locked = 0;
            snd = 1;
        end
        for (int v = 0; v < NUM_VC; v++) begin
            int d;
            d = int'(m_cin[v]) - ((svc == v) ? 1 : 0);
            if (m_cred[v] + d > BUF_DEPTH) m_err = 1;
            else m_cred[v] = m_cred[v] + d;
        end
        if (snd) begin m_out = f; exp_q.push_back(f); end
        else m_out[P_VALID] = 1'b0;
    endtask

    // One clock: check combinational ready, advance model at the edge, check registers.
    task automatic cycle();
        logic [WIDTH-1:0] e;
        #1;
        model_eval();
        check("req_ready", bus.req_ready, m_rdy);
        m_acc = bus.req_valid & m_rdy;
        m_cin = bus.credits_in;
        @(posedge clk);
        model_step();
        #2;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : m_out;
        check("flit_out", bus.o_flit_out, e);
        check("credit_cnt", bus.credit_cnt, exp_cnt());
        check("owner", bus.owner, m_owner[1:0]);
        check("proto_err", bus.proto_err, m_err);
        check("state", st, m_locked);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.credits_in = '0;
        for (int i = 0; i < NUM_REQ; i++) set_flit(i, mk_flit(1, 1, 0, 4'd0, i));
        bus.req_valid = '1;
        model_reset();
        @(posedge clk);
        #2;
        check("rst_flit", bus.o_flit_out, '0);
        check("rst_cnt", bus.credit_cnt, 8'h88);
        check("rst_owner", bus.owner, 2'd0);
        check("rst_err", bus.proto_err, 1'b0);
        check("rst_state", st, 1'b0);
        check("rst_ready", bus.req_ready, 4'b0000);
        bus.req_valid = '0;
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    int g_len [NUM_REQ], g_pos [NUM_REQ], g_vc [NUM_REQ], g_dest [NUM_REQ];
    bit g_bad [NUM_REQ];
    logic [31:0] g_data [NUM_REQ];

    initial begin
        int pkt;
        logic [31:0] dvals [3];
        bus.req_valid = '0;
        bus.req_flit = '0;
        bus.credits_in = '0;
        dvals[0] = 32'hA; dvals[1] = 32'hB; dvals[2] = 32'hC;

        // Three back-to-back single-flit packets, credits returned behind them.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.req_valid = (k < 3) ? 4'b0001 : 4'b0000;
            if (k < 3) set_flit(0, mk_flit(1, 1, 0, 4'd15, dvals[k]));
            bus.credits_in = (k > 0) ? 2'b01 : 2'b00;
            cycle();
            if (k < 3) check("t1_out", bus.o_flit_out, sent(mk_flit(1, 1, 0, 4'd15, dvals[k])));
            else check("t1_idle_valid", bus.o_flit_out[P_VALID], 1'b0);
        end
        bus.credits_in = '0;
        check("t1_cnt", bus.credit_cnt, 8'h88);

        // Credit exhaustion on VC0, then a single returned credit.
        do_reset();
        pkt = 0;
        for (int k = 0; k < 12; k++) begin
            bus.req_valid = (pkt < 10) ? 4'b0001 : 4'b0000;
            set_flit(0, mk_flit(1, 1, 0, 4'd2, pkt));
            cycle();
            if (m_acc[0]) pkt++;
        end
        check("t2_sent8", pkt, 8);
        check("t2_cnt0", bus.credit_cnt, 8'h80);
        check("t2_ready_low", bus.req_ready, 4'b0000);
        bus.credits_in = 2'b01;
        cycle();
        if (m_acc[0]) pkt++;
        bus.credits_in = 2'b00;
        set_flit(0, mk_flit(1, 1, 0, 4'd2, pkt));
        cycle();
        if (m_acc[0]) pkt++;
        check("t2_sent9", pkt, 9);
        check("t2_cnt_back0", bus.credit_cnt, 8'h80);

        // Four always-valid requesters: strict rotation, no idle cycles.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_flit(i, mk_flit(1, 1, 0, 4'(i), 32'h100 + i));
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            bus.credits_in = (k > 0) ? 2'b01 : 2'b00;
            #1;
            check("t3_grant", bus.req_ready, 4'b0001 << (k % 4));
            cycle();
            check("t3_no_bubble", bus.o_flit_out[P_VALID], 1'b1);
        end
        bus.req_valid = '0;
        bus.credits_in = '0;

        // Four-flit packet holds the port against a contender; body vc rewritten to lock vc.
        do_reset();
        set_flit(1, mk_flit(1, 1, 0, 4'd9, 32'h1111));
        for (int k = 0; k < 5; k++) begin
            bus.req_valid = (k < 4) ? 4'b0011 : 4'b0010;
            if (k < 4) set_flit(0, mk_flit(k == 0, k == 3, (k == 0), 4'd3, 32'h200 + k));
            #1;
            check("t4_ready", bus.req_ready, (k < 4) ? 4'b0001 : 4'b0010);
            cycle();
            check("t4_owner", bus.owner, (k < 4) ? 2'd0 : 2'd1);
            if (k > 0 && k < 4) check("t4_lock_vc", bus.o_flit_out[P_VC], 1'b1);
        end
        bus.req_valid = '0;

        // Return and send on VC1 in the same cycle, then a return into a full counter.
        do_reset();
        set_flit(0, mk_flit(1, 1, 1, 4'd5, 32'h55));
        bus.req_valid = 4'b0001;
        bus.credits_in = 2'b10;
        cycle();
        check("t5_cancel_cnt", bus.credit_cnt, 8'h88);
        check("t5_no_err", bus.proto_err, 1'b0);
        bus.req_valid = '0;
        cycle();
        check("t5_full_cnt", bus.credit_cnt, 8'h88);
        check("t5_ovf_err", bus.proto_err, 1'b1);
        bus.credits_in = '0;

        // Reset in the middle of a packet, then an orphan body flit.
        do_reset();
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            set_flit(0, mk_flit(k == 0, 1'b0, 0, 4'd7, 32'h300 + k));
            cycle();
        end
        reset = 1'b0;
        bus.req_valid = '0;
        model_reset();
        #1;
        check("t6_flit_valid", bus.o_flit_out[P_VALID], 1'b0);
        check("t6_cnt", bus.credit_cnt, 8'h88);
        check("t6_state", st, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        set_flit(0, mk_flit(0, 1'b0, 0, 4'd7, 32'h302));
        bus.req_valid = 4'b0001;
        cycle();
        check("t6_orphan_err", bus.proto_err, 1'b1);
        check("t6_orphan_drop", bus.o_flit_out[P_VALID], 1'b0);
        bus.req_valid = '0;

        // Random multi-requester packet traffic with random credit returns.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) g_len[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (g_len[i] == 0 && $urandom_range(0, 2) == 0) begin
                    g_len[i] = $urandom_range(1, 4);
                    g_pos[i] = 0;
                    g_vc[i] = $urandom_range(0, 1);
                    g_dest[i] = $urandom_range(0, 15);
                    g_bad[i] = ($urandom_range(0, 24) == 0);
                    g_data[i] = $urandom;
                end
                bus.req_valid[i] = (g_len[i] > 0);
                set_flit(i, mk_flit(g_pos[i] == 0 && !g_bad[i], g_pos[i] == g_len[i] - 1,
                                    g_vc[i][0], g_dest[i][3:0], g_data[i]));
            end
            for (int v = 0; v < NUM_VC; v++)
                bus.credits_in[v] = (m_cred[v] < BUF_DEPTH) ? ($urandom_range(0, 2) != 0)
                                                            : ($urandom_range(0, 59) == 0);
            cycle();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (m_acc[i]) begin
                    g_pos[i]++;
                    g_data[i] = $urandom;
                    if (g_pos[i] == g_len[i]) g_len[i] = 0;
                end
            end
        end
        bus.req_valid = '0;
        bus.credits_in = '0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
